// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and result channel bundle for alu_op_sequencer
// cmd_*  : command offer (valid/ready) with op select, operands, acc-reuse flag and count
// res_*  : result handshake (valid/ready) carrying the accumulator value
// master : command producer / result consumer side; slave : the sequencer side
interface alu_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [3:0] cmd_cnt;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_cnt, res_ready,
        input  cmd_ready, res_valid, res_data
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_cnt, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: iterates an external combinational ALU N times per command into an accumulator
// clk, rst_n : clock (rising edge) and asynchronous active-low reset
// bus        : command/result channels (slave side)
// abort      : cancels the command in flight (EXEC or DONE), restoring the accumulator
// alu_sel, op_a, op_b : registered op select and operands to the external ALU
// alu_res    : combinational ALU result for the current alu_sel/op_a/op_b
// busy       : high outside IDLE; done_cnt : completed commands, mod 256
module alu_op_sequencer (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_op_sequencer_if.slave         bus,
    input  logic                      abort,
    output logic [1:0]                alu_sel,
    output logic [7:0]                op_a,
    output logic [7:0]                op_b,
    input  logic [7:0]                alu_res,
    output logic                      busy,
    output logic [7:0]                done_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t     state, state_nx;
    logic [7:0] acc;
    logic [7:0] acc_save;
    logic [3:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.cmd_valid ? EXEC : IDLE;
            EXEC:    state_nx = abort ? IDLE : (remaining == 4'd0 ? DONE : EXEC);
            DONE:    state_nx = (abort || bus.res_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = state == IDLE;
        busy          = state != IDLE;
        bus.res_valid = state == DONE;
        bus.res_data  = acc;
    end

    // acc_save snapshots the accumulator at accept so an abort can undo the
    // partial iterations already written into acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 8'd0;
            acc_save  <= 8'd0;
            alu_sel   <= 2'd0;
            op_a      <= 8'd0;
            op_b      <= 8'd0;
            remaining <= 4'd0;
            done_cnt  <= 8'd0;
        end else if (state == IDLE) begin
            if (bus.cmd_valid) begin
                alu_sel   <= bus.cmd_op;
                op_a      <= bus.cmd_use_acc ? acc : bus.cmd_a;
                op_b      <= bus.cmd_b;
                remaining <= bus.cmd_cnt == 4'd0 ? 4'd0 : bus.cmd_cnt - 4'd1;
                acc_save  <= acc;
            end
        end else if (abort) begin
            acc <= acc_save;
        end else if (state == EXEC) begin
            acc <= alu_res;
            if (remaining != 4'd0) begin
                op_a      <= alu_res;
                remaining <= remaining - 4'd1;
            end
        end else if (bus.res_ready) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer against a loop-level reference model
module tb_alu_op_sequencer;
    logic       clk;
    logic       rst_n;
    logic       abort;
    logic [1:0] alu_sel;
    logic [7:0] op_a, op_b, alu_res, done_cnt;
    logic       busy;
    alu_op_sequencer_if bus();

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .abort(abort),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .alu_res(alu_res),
        .busy(busy), .done_cnt(done_cnt)
    );

    function automatic logic [7:0] alu8(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x | y;
        endcase
    endfunction

    assign alu_res = alu8(alu_sel, op_a, op_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    logic [7:0] macc = 8'd0;
    logic [7:0] exp_done = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid && bus.res_ready && !abort) begin
                if (sb.size() == 0) chk("unexpected_result", {24'd0, bus.res_data}, 32'hFFFF_FFFF);
                else chk("result", bus.res_data, sb.pop_front());
            end
        end
    endtask

    function automatic int n_of(input logic [3:0] cnt);
        return cnt == 4'd0 ? 1 : int'(cnt);
    endfunction

    function automatic logic [7:0] ref_run(input logic [1:0] op, input logic [7:0] x,
                                           input logic [7:0] b, input logic [3:0] cnt);
        logic [7:0] r = x;
        for (int i = 0; i < n_of(cnt); i++) r = alu8(op, r, b);
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
    endtask

    task automatic start(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input logic [3:0] cnt, input logic with_abort);
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_use_acc = ua; bus.cmd_cnt = cnt;
        bus.cmd_valid = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        abort = 1'b0;
        chk("accepted", busy, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic ua, input logic [3:0] cnt, input logic with_abort);
        int lat;
        macc = ref_run(op, ua ? macc : a, b, cnt);
        sb.push_back(macc);
        start(op, a, b, ua, cnt, with_abort);
        wait_valid(lat);
        chk("latency", lat, n_of(cnt));
        @(posedge clk); #1;
        exp_done++;
        chk("done_cnt", done_cnt, exp_done);
        chk("idle_after_take", bus.cmd_ready, 1);
    endtask

    initial begin
        int         lat;
        logic [7:0] pre;
        rst_n = 1'b0; abort = 1'b0; bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = 8'd0; bus.cmd_b = 8'd0;
        bus.cmd_use_acc = 1'b0; bus.cmd_cnt = 4'd0;
        fork monitor(); join_none
        #12;
        check_reset_values("por");
        #5 rst_n = 1'b1;
        // single shot, accepted on the first edge after reset release
        run_cmd(2'd0, 8'd3, 8'd4, 1'b0, 4'd0, 1'b0);
        // iteration and 8-bit wrap
        run_cmd(2'd0, 8'h00, 8'h05, 1'b0, 4'd3, 1'b0);
        run_cmd(2'd0, 8'hF0, 8'h10, 1'b0, 4'd2, 1'b0);
        // backpressure holds the result, then reuse the accumulator
        bus.res_ready = 1'b0;
        macc = ref_run(2'd2, 8'hF3, 8'h3C, 4'd2);
        sb.push_back(macc);
        start(2'd2, 8'hF3, 8'h3C, 1'b0, 4'd2, 1'b0);
        wait_valid(lat);
        chk("bp_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_data", bus.res_data, macc);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        exp_done++;
        chk("bp_done_cnt", done_cnt, exp_done);
        run_cmd(2'd1, 8'h77, 8'h01, 1'b1, 4'd0, 1'b0);
        // abort on the third EXEC cycle
        pre = macc;
        start(2'd0, 8'h00, 8'h01, 1'b0, 4'd8, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_exec_busy", busy, 0);
        chk("abort_exec_valid", bus.res_valid, 0);
        chk("abort_exec_done_cnt", done_cnt, exp_done);
        chk("abort_exec_acc", bus.res_data, pre);
        run_cmd(2'd0, 8'h00, 8'h02, 1'b1, 4'd1, 1'b0);
        // abort in DONE wins over res_ready
        pre = macc;
        start(2'd3, 8'h55, 8'h0A, 1'b0, 4'd1, 1'b0);
        wait_valid(lat);
        chk("abort_done_reached", bus.res_valid, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done_busy", busy, 0);
        chk("abort_done_done_cnt", done_cnt, exp_done);
        chk("abort_done_acc", bus.res_data, pre);
        // abort in IDLE is ignored and the command is still accepted
        run_cmd(2'd3, 8'h21, 8'h84, 1'b1, 4'd2, 1'b1);
        // asynchronous reset mid-EXEC discards the command
        start(2'd0, 8'h01, 8'h01, 1'b0, 4'd10, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        macc = 8'd0;
        exp_done = 8'd0;
        @(posedge clk); #4;
        rst_n = 1'b1;
        // 256 random commands wrap done_cnt back to zero
        for (int i = 0; i < 256; i++)
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
        chk("done_cnt_wrap", done_cnt, 8'h00);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-004 The block SHALL have port cmd_ready, output, 1 bit: command accepted when high with cmd_valid.
REQ-005 The block SHALL have port cmd_op, input, 2 bits: ALU operation select for the command.
REQ-006 The block SHALL have port cmd_a, input, 8 bits: operand A.
REQ-007 The block SHALL have port cmd_b, input, 8 bits: operand B.
REQ-008 The block SHALL have port cmd_use_acc, input, 1 bit: 1 = take operand A from the accumulator instead of cmd_a.
REQ-009 The block SHALL have port cmd_cnt, input, 4 bits: iteration count N; 0 is treated as 1.
REQ-010 The block SHALL have port abort, input, 1 bit: synchronous cancel of the command in flight.
REQ-011 The block SHALL have port alu_sel, output, 2 bits: op select driven to the external combinational ALU.
REQ-012 The block SHALL have port op_a, output, 8 bits: ALU operand A, registered.
REQ-013 The block SHALL have port op_b, output, 8 bits: ALU operand B, registered.
REQ-014 The block SHALL have port alu_res, input, 8 bits: combinational ALU result for the current alu_sel/op_a/op_b.
REQ-015 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-016 The block SHALL have port res_data, output, 8 bits: result (accumulator value).
REQ-017 The block SHALL have port res_ready, input, 1 bit: consumer takes the result when high with res_valid.
REQ-018 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-019 The block SHALL have port done_cnt, output, 8 bits: count of completed commands.

Function
REQ-020 The FSM SHALL have the states IDLE, EXEC and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-021 On accept in IDLE (cmd_valid & cmd_ready) the block SHALL latch alu_sel<=cmd_op, op_a<=(cmd_use_acc ? acc : cmd_a), op_b<=cmd_b and remaining<=max(cmd_cnt,1)-1, then enter EXEC.
REQ-022 In EXEC, each clock edge SHALL capture acc<=alu_res.
  - If remaining>0: op_a<=alu_res, remaining decrements, state stays EXEC.
  - Otherwise: state goes to DONE.
REQ-023 op_b and alu_sel SHALL hold constant for all iterations of a command.
REQ-024 Latency SHALL be exactly N cycles from the accept edge to the edge after which res_valid=1, where N=max(cmd_cnt,1).
REQ-025 In DONE, res_valid SHALL be 1 and res_data=acc, both held stable while res_ready=0.
REQ-026 On res_valid & res_ready, the block SHALL enter IDLE and increment done_cnt mod 256 (255 wraps to 0).
REQ-027 No new command SHALL be accepted in the same cycle a result is taken; the earliest accept is the following cycle.
REQ-028 All arithmetic SHALL be 8-bit; wrap-around is the ALU's responsibility and SHALL be passed through unmodified.
REQ-029 abort=1 in EXEC or DONE SHALL return the block to IDLE at the next edge.
  - res_valid SHALL be 0 after that edge.
  - done_cnt SHALL be unchanged.
  - acc SHALL keep its value from before the aborted command.
REQ-030 abort SHALL have priority over res_ready in the same cycle.
REQ-031 abort in IDLE SHALL be ignored, and a command offered in that same cycle SHALL still be accepted.
REQ-032 The accumulator SHALL persist across commands until reset.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, cmd_ready=1, busy=0, res_valid=0, res_data=0, acc=0, alu_sel=0, op_a=0, op_b=0, done_cnt=0, remaining=0.
REQ-034 Reset asserted mid-EXEC or in DONE SHALL discard the command with no result emitted.
REQ-035 The first edge after rst_n rises SHALL be able to accept a command.

Verification (bench ALU model: 00 ADD, 01 SUB, 10 AND, 11 OR, all 8-bit wrap)
REQ-036 Reset check: pulse rst_n low asynchronously, mid-clock -> all outputs at the REQ-033 values immediately, with no clock edge required.
REQ-037 Single-shot: op=00, a=3, b=4, cnt=0, res_ready=1 -> res_valid 1 cycle after accept, res_data=0x07, done_cnt=1.
REQ-038 Iteration and wrap:
  - op=00, a=0x00, b=0x05, cnt=3 -> res_data=0x0F after 3 cycles.
  - op=00, a=0xF0, b=0x10, cnt=2 -> res_data=0x10.
REQ-039 Backpressure and accumulator reuse:
  - Hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0.
  - Then send op=01, use_acc=1, b=0x01 -> result = previous acc - 1.
REQ-040 Abort: op=00, a=0, b=1, cnt=8; assert abort on the 3rd EXEC cycle -> IDLE next edge, no res_valid, done_cnt unchanged, acc = its pre-command value.
REQ-041 Counter wrap: complete 256 commands -> done_cnt returns to 0x00.
